mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/params_pkg.sv | 18 +
 rtl/rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared parameters and types for the memory arbiter slice.
package params_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LINE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  // Width of a port index; a single-port arbiter still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: the lowest requesting index at or above rr_ptr wins,
// otherwise the lowest requesting index below rr_ptr (wrap-around).
module rr_picker #(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned PTR_W = params_pkg::ptr_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] winner,
  output logic                 valid
);

  // Two-pass search: upper segment first, then the wrapped lower segment.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!valid && req[i] && (PTR_W'(i) >= rr_ptr)) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!valid && req[i] && (PTR_W'(i) < rr_ptr)) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin line-memory arbiter: N requester ports share one downstream
// memory port, one transaction outstanding at a time (IDLE/ISSUE/WAIT).
// Optional macro MEM_ARB_PERF_EN adds per-port grant counters on
// debug_gnt_cnt_o.
module mem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int unsigned LINE_BYTES = params_pkg::LINE_BYTES,
  localparam int unsigned LINE_WIDTH = 8 * LINE_BYTES
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [LINE_WIDTH-1:0]                 rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic [LINE_WIDTH-1:0]                 mem_wdata_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [LINE_WIDTH-1:0]                 mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS-1:0][31:0]            debug_gnt_cnt_o
`endif
);

  import params_pkg::*;

  localparam int unsigned PTR_W = ptr_width(NUM_PORTS);

  arb_state_e              state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr, lat_idx, pick_idx, ptr_inc;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [LINE_WIDTH-1:0]   lat_wdata;
  logic [NUM_PORTS-1:0]    pick_oh;
  logic                    pick_valid;
  logic                    issue_gnt, done;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req    (req_i),
    .rr_ptr (rr_ptr),
    .winner (pick_oh),
    .valid  (pick_valid)
  );

  // One-hot winner to index; pointer advance wraps at the last port.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    end
    ptr_inc = (32'(lat_idx) == NUM_PORTS - 1) ? '0 : lat_idx + 1'b1;
  end

  // Grant only in ISSUE; completion either in WAIT or folded into ISSUE.
  always_comb begin
    issue_gnt = (state == ISSUE) && mem_gnt_i;
    done      = (issue_gnt && mem_rvalid_i) || ((state == WAIT) && mem_rvalid_i);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and all outputs; downstream fields forced to 0 outside ISSUE.
  always_comb begin
    state_nxt   = state;
    gnt_o       = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = lat_we;
        mem_addr_o  = lat_addr;
        mem_wdata_o = lat_wdata;
        if (mem_gnt_i) state_nxt = mem_rvalid_i ? IDLE : WAIT;
      end
      WAIT:    if (mem_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (issue_gnt) gnt_o[lat_idx] = 1'b1;
    if (done) begin
      rvalid_o[lat_idx] = 1'b1;
      rdata_o           = mem_rdata_i;
    end
  end

  // Latch the winning request on arbitration; advance pointer on completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr    <= '0;
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      if ((state == IDLE) && pick_valid) begin
        lat_idx   <= pick_idx;
        lat_we    <= we_i[pick_idx];
        lat_addr  <= addr_i[pick_idx];
        lat_wdata <= wdata_i[pick_idx];
      end
      if (done) rr_ptr <= ptr_inc;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [NUM_PORTS-1:0][31:0] gnt_cnt;

  // Per-port grant counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (gnt_o[i]) gnt_cnt[i] <= gnt_cnt[i] + 32'd1;
      end
    end
  end

  assign debug_gnt_cnt_o = gnt_cnt;
`endif

endmodule
